led_frame_reader: RTL

- Downstream consumer of the 1RW1R pixel SRAM's read-only port 1.
- On a start pulse, fetches N pixels of 3 bytes each (G,R,B order) from consecutive SRAM addresses.
- Assembles each pixel into a 24-bit word and presents it on a valid/ready stream to the LED serializer.
- The CPU side writes frames through port 0; this block never writes.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_brightness_scaler.sv | 11 +
 rtl/led_frame_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame reader: FSM states and pixel byte layout.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2,
    PIX   = 2'd3
  } state_e;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int PIX_W           = 24;

  localparam int G_IDX = 0;
  localparam int R_IDX = 1;
  localparam int B_IDX = 2;

endpackage

// File: rtl/led_brightness_scaler.sv
// Scales one colour byte by (brightness+1)/256; brightness=255 passes the byte through.
module led_brightness_scaler (
  input  logic [7:0] byte_i,
  input  logic [7:0] brightness_i,
  output logic [7:0] byte_o
);

  // byte*(brightness+1) never exceeds 255*256, so the product fits in 16 bits.
  assign byte_o = 8'((16'(byte_i) * 16'({1'b0, brightness_i} + 9'd1)) >> 8);

endmodule

// File: rtl/led_frame_reader.sv
// Reads N three-byte pixels from the SRAM read port and streams them as 24-bit {G,R,B} words.
// Optional LED_BRIGHTNESS_EN adds a brightness input that scales every colour byte.
module led_frame_reader
  import led_pkg::*;
#(
  parameter int ASIZE = 10,
  parameter int DSIZE = 8,
  parameter int CSIZE = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [CSIZE-1:0] pix_count,
`ifdef LED_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  output logic             busy,
  output logic             done,
  output logic             mem_cs_n,
  output logic [ASIZE-1:0] mem_addr,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data
);

  state_e             state_q, state_d;
  logic [ASIZE-1:0]   ptr_q, ptr_d;
  logic [CSIZE-1:0]   rem_q, rem_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_cs_n_q, mem_cs_n_d;
  logic [ASIZE-1:0]   mem_addr_q, mem_addr_d;
  logic               pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]   pix_data_q, pix_data_d;
  logic               rd_pend_q;
  logic [1:0]         rd_slot_q;
  logic [DSIZE-1:0]   slot_q [BYTES_PER_PIXEL];
  logic [PIX_W-1:0]   pix_word;
  logic               issue;

`ifdef LED_BRIGHTNESS_EN
  logic [7:0] bright_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= 8'd0;
    end else if (state_q == IDLE && start && !abort && pix_count != '0) begin
      bright_q <= brightness;
    end
  end
`endif

  // The byte arriving this cycle bypasses its slot so LAST can assemble the word without waiting.
  generate
    for (genvar gi = 0; gi < BYTES_PER_PIXEL; gi++) begin : g_slot
      logic [DSIZE-1:0] byte_now;
      assign byte_now = (rd_pend_q && rd_slot_q == 2'(gi)) ? mem_rdata : slot_q[gi];
`ifdef LED_BRIGHTNESS_EN
      led_brightness_scaler u_scale (
        .byte_i       (byte_now),
        .brightness_i (bright_q),
        .byte_o       (pix_word[PIX_W-1-DSIZE*gi -: DSIZE])
      );
`else
      assign pix_word[PIX_W-1-DSIZE*gi -: DSIZE] = byte_now;
`endif
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    byte_idx_d  = byte_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_cs_n_d  = 1'b1;
    mem_addr_d  = mem_addr_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    issue       = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      pix_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (pix_count != '0) begin
              state_d    = FETCH;
              rem_d      = pix_count;
              busy_d     = 1'b1;
              byte_idx_d = 2'd0;
              issue      = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        FETCH: begin
          // byte_idx_q names the byte whose read is on the bus this cycle.
          if (byte_idx_q == 2'd2) begin
            state_d = LAST;
          end else begin
            byte_idx_d = 2'(byte_idx_q + 2'd1);
            issue      = 1'b1;
          end
        end
        LAST: begin
          pix_data_d  = pix_word;
          pix_valid_d = 1'b1;
          state_d     = PIX;
        end
        PIX: begin
          if (pix_ready) begin
            pix_valid_d = 1'b0;
            if (rem_q == CSIZE'(1)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              rem_d      = rem_q - CSIZE'(1);
              byte_idx_d = 2'd0;
              issue      = 1'b1;
              state_d    = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Reads are registered one cycle ahead so chip-select is low during each FETCH cycle.
    if (issue) begin
      mem_cs_n_d = 1'b0;
      mem_addr_d = (state_q == IDLE) ? base_addr : ptr_q;
      ptr_d      = mem_addr_d + ASIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      byte_idx_q  <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_cs_n_q  <= 1'b1;
      mem_addr_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      byte_idx_q  <= byte_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_cs_n_q  <= mem_cs_n_d;
      mem_addr_q  <= mem_addr_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_slot_q <= 2'd0;
      for (int i = 0; i < BYTES_PER_PIXEL; i++) slot_q[i] <= '0;
    end else begin
      rd_pend_q <= !mem_cs_n_q && !abort;
      rd_slot_q <= byte_idx_q;
      if (rd_pend_q && !abort) slot_q[rd_slot_q] <= mem_rdata;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_cs_n  = mem_cs_n_q;
  assign mem_addr  = mem_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

endmodule
